esp32_prog_sequencer: RTL
=========================

Name: esp32_prog_sequencer

Overview:
- Sequences ESP32 reset/boot-strap entry from the FTDI modem lines (nDTR/nRTS) in the ULX3S USB-to-WiFi passthrough.
- Enforces a minimum EN-low time and a strap hold window, during which the GPIO2 strap (sd_d[0]) is driven.
- Arbitrates the shared sd_d[0] pin between strap drive and the OLED SPI MISO return path.
- Sits between the top-level pins and the UART passthrough, which is outside this block.

Parameters:
C_SYNC_STAGES, 2, synchroniser depth for ftdi_ndtr/ftdi_nrts (min 2).
C_EN_LOW_MIN, 2500, minimum EN-low cycles (100 us at 25 MHz); range 1..65535.
C_HOLD_BITS, 17, strap hold window = 2^C_HOLD_BITS cycles.

Ports:
clk_25MHz  in  1  sole clock, 25 MHz.
resetn  in  1  asynchronous active-low reset.
ftdi_ndtr  in  1  FTDI nDTR, asynchronous.
ftdi_nrts  in  1  FTDI nRTS, asynchronous.
btn_boot_n  in  1  button, 0 = force GPIO0 low; already debounced.
oled_csn  in  1  OLED chip select, synchronous to clk_25MHz upstream.
spi_miso_bit  in  1  MISO bit to present on sd_d[0] while oled_csn=0.
wifi_en  out  1  ESP32 EN.
wifi_gpio0  out  1  ESP32 GPIO0 strap.
sd_d0_out  out  1  drive value for sd_d[0].
sd_d0_oe  out  1  output enable for sd_d[0]; the top level builds the tristate.
prog_active  out  1  1 in RESET or BOOT_HOLD (LED).
state_dbg  out  2  current state encoding.

Behaviour:
- Interface: single clock clk_25MHz; reset is asynchronous, active-low (resetn).
- Reset values:
  - state IDLE; counters 0; sync flops 1 (pattern 11).
  - wifi_en=1, wifi_gpio0=1, sd_d0_oe=0, sd_d0_out=0, prog_active=0, state_dbg=00.
- Decode of the synchronised pair p={ndtr,nrts}:
  - 10 = RST (EN 0, IO0 1).
  - 01 = BOOT (EN 1, IO0 0).
  - 00/11 = NEUTRAL.
- All outputs are registered.
- Latency: pin edge -> output change in C_SYNC_STAGES+1 cycles (3 at default).
- States (state_dbg encoding):
  - IDLE (00):
    - EN=1, GPIO0=btn_boot_n.
    - p=RST -> RESET, counter cleared.
  - RESET (01):
    - EN=0, GPIO0=1, strap drive sd_d0 = 1.
    - Counter increments and saturates at C_EN_LOW_MIN.
    - Exit only once counter >= C_EN_LOW_MIN:
      - p=BOOT -> BOOT_HOLD (hold counter cleared).
      - p=NEUTRAL -> IDLE (plain reboot).
    - Before the minimum, stay in RESET regardless of p. This stretches short DTR/RTS pulses.
  - BOOT_HOLD (10):
    - EN=1, GPIO0=0, strap drive sd_d0 = 0.
    - Hold counter counts 2^C_HOLD_BITS cycles regardless of p (covers the esptool 01->11 transition).
    - p=RST at any point -> RESET, counter cleared.
    - Counter wrap (MSB set) -> PROG.
  - PROG (11):
    - EN and GPIO0 follow decode directly: RST gives EN 0 / IO0 1; BOOT gives EN 1 / IO0 0; NEUTRAL gives EN 1 / IO0 1.
    - GPIO0 is additionally ANDed with btn_boot_n.
    - p=RST -> RESET.
    - p=NEUTRAL held continuously 2^C_HOLD_BITS cycles -> IDLE. The idle counter resets on any non-NEUTRAL p.
- sd_d[0] arbitration, priority high to low:
  - State RESET or BOOT_HOLD: oe=1, out=strap value. Overrides OLED even if oled_csn=0.
  - oled_csn=0: oe=1, out=spi_miso_bit.
  - Otherwise oe=0.
- prog_active = (state==RESET or BOOT_HOLD).
- Simultaneous events: RST pattern in BOOT_HOLD on the same cycle as hold wrap -> RESET wins.
- Mid-operation resetn assertion: all outputs return to reset values asynchronously; the next entry starts fresh.
- Counters: RESET counter 16 bit saturating; hold/idle counter C_HOLD_BITS+1 bits.

Test Plan:
(sim parameters C_EN_LOW_MIN=8, C_HOLD_BITS=4)
1. After reset release with pins 11 -> wifi_en=1, wifi_gpio0=1, sd_d0_oe=0, state_dbg=00; btn_boot_n=0 -> wifi_gpio0=0 within 1 cycle.
2. esptool sequence: pins 10 for 20 cycles, then 01 for 5, then 11 -> EN low from cycle 3 for 20 cycles; GPIO0=0 and sd_d0 driven 0 for exactly 16 cycles from BOOT_HOLD entry; then PROG with EN=1, GPIO0=1.
3. Short reset glitch: pins 10 for 2 cycles then 11 -> EN low for exactly 8 cycles, then IDLE, prog_active=0 throughout exit.
4. Arbitration: oled_csn=0, spi_miso_bit toggling, in IDLE -> sd_d0_oe=1, out tracks MISO. Then force the RESET state -> out=1 regardless of MISO; after return to IDLE, MISO path restored.
5. Re-trigger: pins 10 during BOOT_HOLD cycle 15 (same cycle as wrap) -> state RESET, EN=0, hold counter cleared.
6. resetn pulsed low during BOOT_HOLD -> outputs immediately EN=1, GPIO0=1, oe=0, state 00; subsequent 16 cycles of NEUTRAL produce no transitions.

Source files
------------

// File: rtl/esp32_prog_sequencer.sv
// ESP32 reset / boot-strap sequencer driven by the FTDI modem lines.
// Stretches EN-low pulses to a minimum width, holds the GPIO2 strap on
// sd_d[0] for a fixed window after boot entry, and shares sd_d[0] with the
// OLED SPI MISO return path.
module esp32_prog_sequencer #(
    parameter int unsigned C_SYNC_STAGES = 2,
    parameter int unsigned C_EN_LOW_MIN  = 2500,
    parameter int unsigned C_HOLD_BITS   = 17
) (
    input  logic       clk_25MHz,
    input  logic       resetn,
    input  logic       ftdi_ndtr,
    input  logic       ftdi_nrts,
    input  logic       btn_boot_n,
    input  logic       oled_csn,
    input  logic       spi_miso_bit,
    output logic       wifi_en,
    output logic       wifi_gpio0,
    output logic       sd_d0_out,
    output logic       sd_d0_oe,
    output logic       prog_active,
    output logic [1:0] state_dbg
);

    localparam int unsigned RST_CNT_W  = 16;
    localparam int unsigned HOLD_CNT_W = C_HOLD_BITS + 1;

    localparam logic [RST_CNT_W-1:0] EN_LOW_MIN = RST_CNT_W'(C_EN_LOW_MIN);

    localparam logic [1:0] P_RST  = 2'b10;
    localparam logic [1:0] P_BOOT = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_RESET     = 2'b01,
        S_BOOT_HOLD = 2'b10,
        S_PROG      = 2'b11
    } state_e;

    logic [1:0]            sync_q [C_SYNC_STAGES];
    logic [1:0]            pair;
    logic                  p_rst;
    logic                  p_boot;
    logic                  p_neutral;

    state_e                state_q,    state_d;
    logic [RST_CNT_W-1:0]  rst_cnt_q,  rst_cnt_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [RST_CNT_W-1:0]  rst_cnt_inc;
    logic [HOLD_CNT_W-1:0] hold_cnt_inc;

    logic                  en_d;
    logic                  gpio0_d;
    logic                  sd_out_d;
    logic                  sd_oe_d;
    logic                  active_d;

    // Synchronise the {nDTR, nRTS} pair into the clock domain.
    always_ff @(posedge clk_25MHz or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= 2'b11;
            end
        end else begin
            sync_q[0] <= {ftdi_ndtr, ftdi_nrts};
            for (int i = 1; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign pair      = sync_q[C_SYNC_STAGES-1];
    assign p_rst     = (pair == P_RST);
    assign p_boot    = (pair == P_BOOT);
    assign p_neutral = !p_rst && !p_boot;

    // Next state, counters and next output values.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        hold_cnt_d = hold_cnt_q;
        en_d       = 1'b1;
        gpio0_d    = 1'b1;
        sd_out_d   = 1'b0;
        sd_oe_d    = 1'b0;
        active_d   = 1'b0;

        // The EN-low counter saturates so a long RST level cannot wrap it.
        rst_cnt_inc  = (rst_cnt_q >= EN_LOW_MIN) ? rst_cnt_q
                                                 : rst_cnt_q + RST_CNT_W'(1);
        hold_cnt_inc = hold_cnt_q + HOLD_CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (p_rst) begin
                    state_d   = S_RESET;
                    rst_cnt_d = '0;
                end
            end
            S_RESET: begin
                rst_cnt_d = rst_cnt_inc;
                // The current cycle counts towards the minimum EN-low time.
                if (rst_cnt_inc >= EN_LOW_MIN) begin
                    if (p_boot) begin
                        state_d    = S_BOOT_HOLD;
                        hold_cnt_d = '0;
                    end else if (p_neutral) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_BOOT_HOLD: begin
                // A new RST request outranks the end of the hold window.
                if (p_rst) begin
                    state_d    = S_RESET;
                    rst_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_inc[HOLD_CNT_W-1]) begin
                    state_d    = S_PROG;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_inc;
                end
            end
            S_PROG: begin
                // Counter reused to time an unbroken NEUTRAL run.
                if (p_rst) begin
                    state_d    = S_RESET;
                    rst_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (!p_neutral) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_inc[HOLD_CNT_W-1]) begin
                    state_d    = S_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_IDLE: begin
                gpio0_d = btn_boot_n;
            end
            S_RESET: begin
                en_d     = 1'b0;
                sd_out_d = 1'b1;
                sd_oe_d  = 1'b1;
                active_d = 1'b1;
            end
            S_BOOT_HOLD: begin
                gpio0_d  = 1'b0;
                sd_out_d = 1'b0;
                sd_oe_d  = 1'b1;
                active_d = 1'b1;
            end
            S_PROG: begin
                en_d    = !p_rst;
                gpio0_d = !p_boot && btn_boot_n;
            end
            default: begin
                en_d = 1'b1;
            end
        endcase

        // OLED MISO may use sd_d[0] only when no strap is being driven.
        if (!sd_oe_d && !oled_csn) begin
            sd_oe_d  = 1'b1;
            sd_out_d = spi_miso_bit;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_25MHz or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            wifi_en     <= 1'b1;
            wifi_gpio0  <= 1'b1;
            sd_d0_out   <= 1'b0;
            sd_d0_oe    <= 1'b0;
            prog_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            wifi_en     <= en_d;
            wifi_gpio0  <= gpio0_d;
            sd_d0_out   <= sd_out_d;
            sd_d0_oe    <= sd_oe_d;
            prog_active <= active_d;
        end
    end

    assign state_dbg = state_q;

endmodule
